avg_period_counter: RTL and testbench

AVG_PERIOD_COUNTER -- requirements
Module: avg_period_counter

---
 rtl/avg_period_pkg.sv | 16 +
 rtl/sat_accum.sv | 28 ++
 rtl/avg_period_counter.sv | 130 +++++++++++++
 tb/tb_avg_period_counter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_period_pkg.sv
// Shared definitions for avg_period_counter: FSM state encoding and accumulator sizing.
package avg_period_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS,
    ST_DONE
  } state_t;

  // The accumulator holds the sum of 2**avg_log2 periods, so it needs avg_log2 extra bits.
  function automatic int acc_width(input int width, input int avg_log2);
    return width + avg_log2;
  endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating up-counter: sticks at all-ones and latches a flag on any increment beyond it.
module sat_accum
  import avg_period_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             saturated
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value     <= '0;
      saturated <= 1'b0;
    end else if (inc) begin
      if (value == '1) begin
        saturated <= 1'b1;
      end else begin
        value <= value + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/avg_period_counter.sv
// Measures the average spacing of tick_i pulses over 2**AVG_LOG2 periods, in clk_i cycles.
// Optional abort on a stalled input is compiled in with `define AVG_PERIOD_TIMEOUT_EN.
module avg_period_counter
  import avg_period_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             tick_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] period_o,
  output logic             overflow_o
`ifdef AVG_PERIOD_TIMEOUT_EN
  ,
  output logic             timeout_o
`endif
);

  localparam int ACC_W = acc_width(WIDTH, AVG_LOG2);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'((1 << AVG_LOG2) - 1);

  if (WIDTH < 1 || AVG_LOG2 < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("avg_period_counter: invalid parameter values");
  end

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             acc_sat;
  logic [CNT_W-1:0] tick_cnt;
  logic             acc_clear;
  logic             acc_inc;
  logic             to_hit;

  // The arming tick starts a fresh sum; every MEAS cycle (tick cycles included) adds one.
  assign acc_clear = (state == ST_ARM) && tick_i;
  assign acc_inc   = (state == ST_MEAS);

  sat_accum #(
    .WIDTH(ACC_W)
  ) u_accum (
    .clk      (clk_i),
    .rst      (reset_i),
    .clear    (acc_clear),
    .inc      (acc_inc),
    .value    (acc),
    .saturated(acc_sat)
  );

`ifdef AVG_PERIOD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_hit = ((state == ST_ARM) || (state == ST_MEAS)) && !tick_i &&
                  (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts cycles since the last tick (or since arming); idle states keep it at zero.
  always_ff @(posedge clk_i) begin
    if (reset_i || to_hit || tick_i || state == ST_IDLE || state == ST_DONE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
    timeout_o <= !reset_i && to_hit;
  end
`else
  assign to_hit = 1'b0;
`endif

  // The final tick's own increment lands in acc at the same edge the result is captured,
  // so the result is taken from the accumulator's next value to meet one-cycle latency.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ST_IDLE;
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
      period_o   <= '0;
      overflow_o <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state   <= ST_ARM;
            ready_o <= 1'b0;
          end
        end
        ST_ARM: begin
          if (tick_i) begin
            state    <= ST_MEAS;
            tick_cnt <= '0;
          end else if (to_hit) begin
            state   <= ST_IDLE;
            ready_o <= 1'b1;
          end
        end
        ST_MEAS: begin
          if (tick_i) begin
            if (tick_cnt == LAST_TICK) begin
              state      <= ST_DONE;
              done_o     <= 1'b1;
              period_o   <= WIDTH'(((acc == '1) ? acc : acc + ACC_W'(1)) >> AVG_LOG2);
              overflow_o <= acc_sat || (acc == '1);
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end else if (to_hit) begin
            state   <= ST_IDLE;
            ready_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avg_period_counter.sv
// Bench for avg_period_counter: a WIDTH=16/AVG_LOG2=2 instance and a WIDTH=8/AVG_LOG2=0 instance.
`timescale 1ns/1ps
module tb_avg_period_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic       tick  [2];
  logic       ready [2];
  logic       done  [2];
  logic       ovf   [2];
  logic [15:0] per_a;
  logic [7:0]  per_b;
`ifdef AVG_PERIOD_TIMEOUT_EN
  logic       tmo   [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_period [2];
  int w_of [2];
  int l_of [2];

  always #5 clk = ~clk;

  avg_period_counter #(.WIDTH(16), .AVG_LOG2(2), .TIMEOUT_CYCLES(100)) dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(start[0]), .tick_i(tick[0]),
    .ready_o(ready[0]), .done_o(done[0]), .period_o(per_a), .overflow_o(ovf[0])
`ifdef AVG_PERIOD_TIMEOUT_EN
    , .timeout_o(tmo[0])
`endif
  );

  avg_period_counter #(.WIDTH(8), .AVG_LOG2(0), .TIMEOUT_CYCLES(1000)) dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(start[1]), .tick_i(tick[1]),
    .ready_o(ready[1]), .done_o(done[1]), .period_o(per_b), .overflow_o(ovf[1])
`ifdef AVG_PERIOD_TIMEOUT_EN
    , .timeout_o(tmo[1])
`endif
  );

  function automatic int per_of(input int d);
    return (d == 0) ? int'(per_a) : int'(per_b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full measurement: start, wait in ARM, arming tick, then n measured intervals.
  // Expected result comes from the plain sum of intervals, clipped at the accumulator range.
  task automatic run_meas(input string name, input int d, input int n, input int iv[8],
                          input int arm_wait, input bit tick_on_start, input bit start_mid);
    longint total = 0;
    longint maxv;
    int     exp_p;
    bit     exp_o;
    int     bad_done = 0;
    int     bad_hold = 0;
    int     prev = exp_period[d];
    for (int k = 0; k < n; k++) total += iv[k];
    maxv  = (longint'(1) << (w_of[d] + l_of[d])) - 1;
    exp_o = (total > maxv);
    exp_p = int'((exp_o ? maxv : total) >> l_of[d]);

    n_checks++;
    if (ready[d] !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before_start: got %0b want 1", name, ready[d]);
    end
    start[d] = 1'b1; tick[d] = tick_on_start;
    step();
    start[d] = 1'b0; tick[d] = 1'b0;
    n_checks++;
    if (ready[d] !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_after_start: got %0b want 0", name, ready[d]);
    end
    for (int c = 0; c < arm_wait; c++) begin
      step();
      if (done[d] !== 1'b0) bad_done++;
      if (per_of(d) !== prev) bad_hold++;
    end
    tick[d] = 1'b1;
    step();
    tick[d] = 1'b0;
    if (done[d] !== 1'b0) bad_done++;
    if (per_of(d) !== prev) bad_hold++;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < iv[k] - 1; c++) begin
        if (start_mid && k == 0 && c == 0) start[d] = 1'b1;
        step();
        start[d] = 1'b0;
        if (done[d] !== 1'b0) bad_done++;
        if (per_of(d) !== prev) bad_hold++;
      end
      tick[d] = 1'b1;
      step();
      tick[d] = 1'b0;
      if (k != n - 1) begin
        if (done[d] !== 1'b0) bad_done++;
        if (per_of(d) !== prev) bad_hold++;
      end
    end

    n_checks++;
    if (done[d] !== 1'b1) begin
      n_fail++; $display("FAIL %s done_after_last_tick: got %0b want 1", name, done[d]);
    end
    n_checks++;
    if (per_of(d) !== exp_p) begin
      n_fail++; $display("FAIL %s period: got %0d want %0d", name, per_of(d), exp_p);
    end
    n_checks++;
    if (ovf[d] !== exp_o) begin
      n_fail++; $display("FAIL %s overflow: got %0b want %0b", name, ovf[d], exp_o);
    end
    step();
    n_checks++;
    if (done[d] !== 1'b0) begin
      n_fail++; $display("FAIL %s done_width: got %0b want 0", name, done[d]);
    end
    n_checks++;
    if (ready[d] !== 1'b1 || per_of(d) !== exp_p) begin
      n_fail++;
      $display("FAIL %s idle_after_done: ready=%0b period=%0d want ready=1 period=%0d",
               name, ready[d], per_of(d), exp_p);
    end
    n_checks++;
    if (bad_done !== 0 || bad_hold !== 0) begin
      n_fail++;
      $display("FAIL %s during_measure: early done cycles=%0d period changes=%0d want 0/0",
               name, bad_done, bad_hold);
    end
    exp_period[d] = exp_p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (ready[d] !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready[%0d]: got %0b want 1", d, ready[d]);
      end
      n_checks++;
      if (done[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_done[%0d]: got %0b want 0", d, done[d]);
      end
      n_checks++;
      if (per_of(d) !== 0) begin
        n_fail++; $display("FAIL reset_period[%0d]: got %0d want 0", d, per_of(d));
      end
      n_checks++;
      if (ovf[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_overflow[%0d]: got %0b want 0", d, ovf[d]);
      end
`ifdef AVG_PERIOD_TIMEOUT_EN
      n_checks++;
      if (tmo[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_timeout[%0d]: got %0b want 0", d, tmo[d]);
      end
`endif
      exp_period[d] = 0;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fixed_period();
    int iv[8] = '{10, 10, 10, 10, 0, 0, 0, 0};
    run_meas("fixed_10", 0, 4, iv, 3, 1'b0, 1'b0);
  endtask

  task automatic test_jitter();
    int iv[8] = '{10, 11, 10, 11, 0, 0, 0, 0};
    run_meas("jitter_10_11", 0, 4, iv, 0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    int iv[8] = '{300, 0, 0, 0, 0, 0, 0, 0};
    run_meas("sat_300", 1, 1, iv, 2, 1'b0, 1'b0);
    iv[0] = 255;
    run_meas("edge_255", 1, 1, iv, 0, 1'b0, 1'b0);
    iv[0] = 256;
    run_meas("edge_256", 1, 1, iv, 1, 1'b0, 1'b0);
  endtask

  task automatic test_start_tick();
    int iv[8] = '{20, 20, 20, 20, 0, 0, 0, 0};
    run_meas("start_with_tick", 0, 4, iv, 19, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int iv[8];
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) iv[k] = int'($urandom_range(1, 40));
      run_meas("random_a", 0, 4, iv, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
               (iv[0] >= 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      iv[0] = int'($urandom_range(100, 400));
      run_meas("random_b", 1, 1, iv, int'($urandom_range(0, 5)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int iv[8] = '{7, 9, 8, 6, 0, 0, 0, 0};
    run_meas("b2b_first", 0, 4, iv, 0, 1'b0, 1'b0);
    iv = '{25, 25, 26, 26, 0, 0, 0, 0};
    run_meas("b2b_second", 0, 4, iv, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int bad_done = 0;
    start[0] = 1'b1; step(); start[0] = 1'b0;
    tick[0] = 1'b1; step(); tick[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 9; c++) step();
      tick[0] = 1'b1; step(); tick[0] = 1'b0;
    end
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    exp_period[0] = 0;
    exp_period[1] = 0;
    n_checks++;
    if (ready[0] !== 1'b1 || per_of(0) !== 0 || done[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%0b period=%0d done=%0b ovf=%0b want 1/0/0/0",
               ready[0], per_of(0), done[0], ovf[0]);
    end
    for (int c = 0; c < 40; c++) begin
      tick[0] = ((c % 10) == 9);
      step();
      if (done[0] !== 1'b0) bad_done++;
    end
    tick[0] = 1'b0;
    n_checks++;
    if (bad_done !== 0 || ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_aborted: done cycles=%0d ready=%0b want 0/1", bad_done, ready[0]);
    end
  endtask

`ifdef AVG_PERIOD_TIMEOUT_EN
  task automatic test_timeout();
    int prev = exp_period[0];
    int seen_at = -1;
    int pulses = 0;
    int bad_done = 0;
    start[0] = 1'b1; step(); start[0] = 1'b0;
    tick[0] = 1'b1; step(); tick[0] = 1'b0;
    for (int c = 0; c < 9; c++) step();
    tick[0] = 1'b1; step(); tick[0] = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      step();
      if (tmo[0] === 1'b1) begin
        pulses++;
        if (seen_at < 0) seen_at = c;
      end
      if (done[0] !== 1'b0) bad_done++;
    end
    n_checks++;
    if (seen_at !== 100) begin
      n_fail++; $display("FAIL timeout_latency: got %0d want 100", seen_at);
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL timeout_width: got %0d want 1", pulses);
    end
    n_checks++;
    if (bad_done !== 0 || ready[0] !== 1'b1 || per_of(0) !== prev) begin
      n_fail++;
      $display("FAIL timeout_state: done cycles=%0d ready=%0b period=%0d want 0/1/%0d",
               bad_done, ready[0], per_of(0), prev);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    w_of[0] = 16; l_of[0] = 2;
    w_of[1] = 8;  l_of[1] = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      tick[d]  = 1'b0;
    end
    test_reset();
    test_fixed_period();
    test_jitter();
    test_overflow();
    test_start_tick();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef AVG_PERIOD_TIMEOUT_EN
    test_fixed_period();
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
